// File: rtl/mvm_stream_engine.sv
// rtl/mvm_stream_engine.sv - streaming matrix-vector multiply engine, y = sat(round(W*x))
// Optional bias add guarded by MVM_BIAS_ADD_EN.
module mvm_stream_engine #(
    parameter int NROW          = 16,
    parameter int NCOL          = 16,
    parameter int QN            = 6,
    parameter int QM            = 11,
    parameter int BITWIDTH      = QN + QM + 1,
    parameter int ADDR_BITWIDTH = (NCOL > 1) ? $clog2(NCOL) : 1,
    parameter int ACC_BITWIDTH  = 2 * BITWIDTH + $clog2(NCOL)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BITWIDTH-1:0]        in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [ADDR_BITWIDTH-1:0]   col_addr,
    input  logic [NROW*BITWIDTH-1:0]   weight_col,
`ifdef MVM_BIAS_ADD_EN
    input  logic [NROW*BITWIDTH-1:0]   bias_vec,
`endif
    output logic [NROW*BITWIDTH-1:0]   out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy
);

    localparam int PW = 2 * BITWIDTH;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_COL = ADDR_BITWIDTH'(NCOL - 1);
    localparam logic signed [ACC_BITWIDTH-1:0] RND     = ACC_BITWIDTH'(2 ** (QM - 1));
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_MAX = ACC_BITWIDTH'(2 ** (BITWIDTH - 1) - 1);
    localparam logic signed [ACC_BITWIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_OUT} state_t;

    state_t                          state_q, state_d;
    logic [ADDR_BITWIDTH-1:0]        cnt_q, cnt_d;
    logic signed [BITWIDTH-1:0]      x_q, x_d;
    logic                            mac_en_q, mac_en_d;
    logic signed [ACC_BITWIDTH-1:0]  acc_q [NROW];
    logic signed [ACC_BITWIDTH-1:0]  acc_d [NROW];
    logic signed [PW-1:0]            prod  [NROW];
    logic [NROW*BITWIDTH-1:0]        out_data_q, out_data_d;
    logic                            out_valid_q, out_valid_d;
    logic                            accept;
`ifdef MVM_BIAS_ADD_EN
    logic [NROW*BITWIDTH-1:0]        bias_q, bias_d;
`endif

    function automatic logic [BITWIDTH-1:0] round_sat(input logic signed [ACC_BITWIDTH-1:0] a);
        logic signed [ACC_BITWIDTH-1:0] t;
        t = (a + RND) >>> QM;
        if (t > SAT_MAX)      t = SAT_MAX;
        else if (t < SAT_MIN) t = SAT_MIN;
        return t[BITWIDTH-1:0];
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_ACC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:   if (accept && cnt_q == LAST_COL) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_OUT;
            ST_OUT:   if (out_ready) state_d = ST_ACC;
            default:  state_d = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_ACC);
        busy     = (cnt_q != '0) || (state_q != ST_ACC);
        col_addr = cnt_q;
    end

    assign accept    = in_valid && in_ready;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        cnt_d       = cnt_q;
        x_d         = x_q;
        mac_en_d    = accept;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef MVM_BIAS_ADD_EN
        bias_d      = (accept && cnt_q == '0) ? bias_vec : bias_q;
`endif
        if (accept) begin
            cnt_d = (cnt_q == LAST_COL) ? '0 : cnt_q + 1'b1;
            x_d   = in_data;
        end
        for (int r = 0; r < NROW; r++) begin
            prod[r]  = PW'($signed(weight_col[r*BITWIDTH +: BITWIDTH])) * PW'(x_q);
            acc_d[r] = acc_q[r];
            if (mac_en_q) acc_d[r] = acc_q[r] + ACC_BITWIDTH'(prod[r]);
            if (state_q == ST_OUT && out_ready) acc_d[r] = '0;
        end
        // The output register captures the accumulator including the final MAC done in DRAIN.
        if (state_q == ST_DRAIN) begin
            out_valid_d = 1'b1;
            for (int r = 0; r < NROW; r++) begin
`ifdef MVM_BIAS_ADD_EN
                out_data_d[r*BITWIDTH +: BITWIDTH] = round_sat(acc_d[r] +
                    (ACC_BITWIDTH'($signed(bias_q[r*BITWIDTH +: BITWIDTH])) <<< QM));
`else
                out_data_d[r*BITWIDTH +: BITWIDTH] = round_sat(acc_d[r]);
`endif
            end
        end
        if (state_q == ST_OUT && out_ready) out_valid_d = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            x_q         <= '0;
            mac_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int r = 0; r < NROW; r++) acc_q[r] <= '0;
`ifdef MVM_BIAS_ADD_EN
            bias_q      <= '0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            mac_en_q    <= mac_en_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            for (int r = 0; r < NROW; r++) acc_q[r] <= acc_d[r];
`ifdef MVM_BIAS_ADD_EN
            bias_q      <= bias_d;
`endif
        end
    end

endmodule

// File: tb/tb_mvm_stream_engine.sv
// tb/tb_mvm_stream_engine.sv - randomized self-checking bench for mvm_stream_engine against a sum-of-products model
module tb_mvm_stream_engine;
    localparam int NROW = 16;
    localparam int NCOL = 16;
    localparam int QM   = 11;
    localparam int BW   = 18;
    localparam int AW   = 4;
    localparam int DW   = NROW * BW;
`ifdef MVM_BIAS_ADD_EN
    localparam int BIAS_Y = 2048;
`else
    localparam int BIAS_Y = 0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] col_addr;
    logic [DW-1:0] weight_col = '0;
    logic [DW-1:0] bias_vec;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;

    int w_mem [NROW][NCOL];
    int x_vec [NCOL];
    int bias  [NROW];
    int total = 0;
    int bad   = 0;
    logic [DW-1:0] last_out;

    mvm_stream_engine dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .col_addr   (col_addr),
        .weight_col (weight_col),
`ifdef MVM_BIAS_ADD_EN
        .bias_vec   (bias_vec),
`endif
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock)
        for (int r = 0; r < NROW; r++) weight_col[r*BW +: BW] <= BW'(w_mem[r][col_addr]);

    always_comb
        for (int r = 0; r < NROW; r++) bias_vec[r*BW +: BW] = BW'(bias[r]);

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model();
        logic [DW-1:0] y;
        longint s;
        for (int r = 0; r < NROW; r++) begin
            s = 0;
            for (int j = 0; j < NCOL; j++) s += longint'(w_mem[r][j]) * longint'(x_vec[j]);
`ifdef MVM_BIAS_ADD_EN
            s += longint'(bias[r]) * 2048;
`endif
            s = (s + 1024) >>> QM;
            if (s > 131071)  s = 131071;
            if (s < -131072) s = -131072;
            y[r*BW +: BW] = BW'(s);
        end
        return y;
    endfunction

    function automatic int rnd_val(input int full);
        if (full != 0) return int'($urandom_range(0, 262143)) - 131072;
        return int'($urandom_range(0, 8191)) - 4096;
    endfunction

    // gap_mode: 0 = back-to-back, 1 = toggle, 2 = random
    task automatic run_vector(input string tag, input int gap_mode, input int hold);
        logic [DW-1:0] exp;
        int j, cyc, lat;
        logic v;
        exp = model();
        j = 0;
        cyc = 0;
        @(negedge clock);
        chk({tag, "_rdy_start"}, in_ready, 1'b1);
        while (j < NCOL && cyc < 500) begin
            if (cyc != 0) @(negedge clock);
            cyc++;
            v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? cyc[0] : ($urandom_range(0, 3) != 0);
            in_valid  = v;
            in_data   = v ? BW'(x_vec[j]) : BW'($urandom);
            out_ready = $urandom_range(0, 1) != 0;
            if (v && in_ready) begin
                @(posedge clock);
                j++;
            end
        end
        chk({tag, "_accepts"}, j, NCOL);
        out_ready = 1'b0;
        for (lat = 1; lat <= 50; lat++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = BW'($urandom);
            chk({tag, "_rdy_low"}, in_ready, 1'b0);
            chk({tag, "_busy"}, busy, 1'b1);
            if (out_valid) break;
        end
        chk({tag, "_latency"}, lat, 2);
        last_out = out_data;
        chk({tag, "_data"}, out_data, exp);
        repeat (hold) begin
            @(negedge clock);
            in_data = BW'($urandom);
            chk({tag, "_hold_data"}, out_data, exp);
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_rdy"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_rdy_back"}, in_ready, 1'b1);
        chk({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic fill(input int w, input int x, input int b);
        for (int r = 0; r < NROW; r++) begin
            bias[r] = b;
            for (int j = 0; j < NCOL; j++) w_mem[r][j] = w;
        end
        for (int j = 0; j < NCOL; j++) x_vec[j] = x;
    endtask

    initial begin
        fill(2048, 2048, 2048);
        #2;
        chk("rst_rdy", in_ready, 1'b1);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_addr", col_addr, '0);
        chk("rst_busy", busy, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        run_vector("nominal", 0, 0);
        chk("nominal_row0", last_out[BW-1:0], BW'(32768 + BIAS_Y));
        chk("nominal_row15", last_out[15*BW +: BW], BW'(32768 + BIAS_Y));

        fill(8192, 8192, 2048);
        run_vector("possat", 0, 0);
        chk("possat_row3", last_out[3*BW +: BW], 18'h1ffff);
        fill(8192, -8192, 2048);
        run_vector("negsat", 0, 0);
        chk("negsat_row3", last_out[3*BW +: BW], 18'h20000);

        fill(0, 0, 2048);
        for (int r = 0; r < NROW; r++) begin
            w_mem[r][0] = 1;
            for (int j = 1; j < NCOL; j++) w_mem[r][j] = rnd_val(1);
        end
        x_vec[0] = 1024;
        run_vector("round_up", 0, 0);
        chk("round_up_row7", last_out[7*BW +: BW], BW'(1 + BIAS_Y));
        x_vec[0] = -1024;
        run_vector("round_neg", 0, 0);
        chk("round_neg_row7", last_out[7*BW +: BW], BW'(BIAS_Y));

        fill(2048, 2048, 2048);
        run_vector("toggle", 1, 5);
        chk("toggle_row9", last_out[9*BW +: BW], BW'(32768 + BIAS_Y));
        run_vector("back2back", 0, 0);

        for (int j = 0; j < NCOL; j++) x_vec[j] = rnd_val(1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = BW'(x_vec[k]);
            @(posedge clock);
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_addr", col_addr, '0);
        chk("midrst_rdy", in_ready, 1'b1);
        chk("midrst_valid", out_valid, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        fill(2048, 2048, 2048);
        run_vector("postrst", 0, 0);
        chk("postrst_row0", last_out[BW-1:0], BW'(32768 + BIAS_Y));

        for (int t = 0; t < 8; t++) begin
            int full;
            full = int'($urandom_range(0, 1));
            for (int r = 0; r < NROW; r++) begin
                bias[r] = rnd_val(0);
                for (int j = 0; j < NCOL; j++) w_mem[r][j] = rnd_val(full);
            end
            for (int j = 0; j < NCOL; j++) x_vec[j] = rnd_val(full);
            run_vector("random", 2, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mvm_stream_engine.md
Name: mvm_stream_engine

Overview:
- Parametrised successor to the current dot-product unit. Computes y = W·x for an NROW×NCOL signed fixed-point matrix W held in an external synchronous weight memory.
- Input vector x is streamed one element per cycle under a valid/ready handshake. The engine drives the column address and performs NROW parallel MACs per column.
- The result is rounded and saturated back to Q(QN.QM), then presented as one packed vector under a valid/ready handshake.
- Sits between the layer input buffer and the activation (sigmoid/tanh) stage of the RNN datapath.

Parameters:
- NROW, 16, output vector length / parallel MAC lanes
- NCOL, 16, input vector length / weight memory depth
- QN, 6, integer bits (excluding sign)
- QM, 11, fractional bits
- BITWIDTH, QN+QM+1, element width (two's complement)
- ADDR_BITWIDTH, $clog2(NCOL), weight column address width
- ACC_BITWIDTH, 2*BITWIDTH+$clog2(NCOL), per-lane accumulator width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_data  in  BITWIDTH  element x[j], signed Q(QN.QM)
- in_valid  in  1  in_data valid
- in_ready  out  1  engine accepts in_data this cycle
- col_addr  out  ADDR_BITWIDTH  weight memory column address
- weight_col  in  NROW*BITWIDTH  column W[*][col_addr], returned 1 cycle after col_addr; row r at bits [r*BITWIDTH +: BITWIDTH]
- out_data  out  NROW*BITWIDTH  packed result y, row r at [r*BITWIDTH +: BITWIDTH]
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high from the first accepted element until the output handshake completes

Behaviour:
- Reset values (reset low, asynchronous):
  - state=ACC, col counter=0, all accumulators=0
  - in_ready=1, out_valid=0, out_data=0, col_addr=0, busy=0
- States:
  - ACC: in_ready=1. Accept occurs when in_valid&in_ready; on accept:
    - col_addr = counter (combinational from counter)
    - x registered into x_q
    - mac_en_q set for the next cycle
    - counter increments
    - accept with counter==NCOL-1: go to DRAIN and drop in_ready the next cycle; counter returns to 0
  - MAC stage (cycle after each accept): acc[r] += sext(weight_col[r]) * sext(x_q), full-precision product (2*BITWIDTH), no overflow inside ACC_BITWIDTH.
  - DRAIN: exactly 1 cycle. Performs the final MAC. in_ready=0. Go to OUT.
  - OUT, entry: register out_data[r] = sat(round(acc[r])):
    - round: add 2^(QM-1), then arithmetic shift right by QM (round half up)
    - sat: clamp to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1]
    - out_valid=1, in_ready=0
  - OUT, hold: out_data and out_valid stay stable while out_ready=0.
  - OUT, exit: on out_valid&out_ready, clear accumulators, out_valid=0 next cycle, return to ACC with in_ready=1.
- Timing:
  - Latency: last element accepted at cycle T → out_valid high at T+2.
  - Throughput: one vector per NCOL+2 cycles with out_ready tied high.
- Boundary conditions:
  - in_valid low mid-vector: pipeline stalls; no MAC for that cycle; counter holds.
  - Gaps of any length are legal.
  - out_ready high before out_valid: no effect.
  - in_valid high during DRAIN/OUT: ignored; data is not consumed.
  - Reset asserted mid-vector or in OUT: immediate return to reset values; the partial result is discarded.
  - NCOL=1: ACC→DRAIN after the first accept.
- busy = (counter!=0) | (state!=ACC).

Optional Feature:
- Macro: MVM_BIAS_ADD_EN
- Defined:
  - adds input port bias_vec (NROW*BITWIDTH, Q(QN.QM)), sampled on the accept of element 0
  - the sampled bias is added to each acc[r] as bias<<QM before round/saturate
- Not defined: no port, no adder; the result is pure W·x.

Test Plan:
- Nominal: NROW=NCOL=16, all weights 2048 (1.0), x[j]=2048 every cycle → every y[r]=32768 (16.0); out_valid exactly 2 cycles after the 16th accept.
- Positive saturation: all weights 8192 (4.0), x=8192 → every y[r]=131071. Negative saturation: weights 8192, x=-8192 → every y[r]=-131072.
- Rounding: W[r][0]=1, x[0]=1024, all other x=0 → y[r]=1 (0.5 LSB rounds up). Repeat with x[0]=-1024 → y[r]=0.
- Handshake: in_valid toggled 1/0 each cycle, then out_ready held low 5 cycles after out_valid:
  - result identical to the gap-free case
  - out_data stable across the hold
  - in_ready=0 throughout DRAIN/OUT
  - second vector accepted the cycle after the handshake
- Reset mid-op: assert reset after 7 accepts; release; stream a full vector of x=2048 with weights 2048 → y[r]=32768, with no residue from the aborted vector.
- MVM_BIAS_ADD_EN: bias_vec all 2048, nominal stimulus → every y[r]=34816 (17.0).
